// File: rtl/mmc1_pkg.sv
// rtl/mmc1_pkg.sv - shared types and constants for the MMC1 register sequencer
package mmc1_pkg;

  typedef enum logic [1:0] {
    MMC1_CTRL = 2'd0,
    MMC1_CHR0 = 2'd1,
    MMC1_CHR1 = 2'd2,
    MMC1_PRG  = 2'd3
  } mmc1_reg_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_RST_WR  = 3'd2,
    ST_RST_GAP = 3'd3,
    ST_BIT_WR  = 3'd4,
    ST_BIT_GAP = 3'd5,
    ST_DONE    = 3'd6
  } mmc1_state_e;

  localparam logic [7:0]  MMC1_RESET_DATA = 8'h80;
  localparam logic [15:0] MMC1_BASE       = 16'h8000;
  localparam logic [4:0]  MMC1_CTRL_RESET = 5'b01100;

  // Register windows sit at $8000/$A000/$C000/$E000.
  function automatic logic [15:0] mmc1_addr(input mmc1_reg_e r);
    return MMC1_BASE | {1'b0, r, 13'h0000};
  endfunction

endpackage

// File: rtl/mmc1_write_pacer.sv
// rtl/mmc1_write_pacer.sv - single-beat write strobe followed by a GAP_BEATS idle window
module mmc1_write_pacer #(
  parameter int GAP_BEATS = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic start,
  input  logic abort,
  output logic write,
  output logic gap_done
);

  localparam logic [2:0] GAP_LOAD = 3'(GAP_BEATS);

  logic [2:0] gap_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write   <= 1'b0;
      gap_cnt <= 3'd0;
    end else if (abort) begin
      write   <= 1'b0;
      gap_cnt <= 3'd0;
    end else if (ce) begin
      if (start) begin
        write   <= 1'b1;
        gap_cnt <= GAP_LOAD;
      end else if (write) begin
        write <= 1'b0;
      end else if (gap_cnt != 3'd0) begin
        gap_cnt <= gap_cnt - 3'd1;
      end
    end
  end

  // Asserted during the last idle beat so the next write can start on the following beat.
  assign gap_done = ce && !write && (gap_cnt == 3'd1);

endmodule

// File: rtl/mmc1_reg_sequencer.sv
// rtl/mmc1_reg_sequencer.sv - loads MMC1 registers through the CPU serial-write protocol
module mmc1_reg_sequencer
  import mmc1_pkg::*;
#(
  parameter int GAP_BEATS   = 1,
  parameter int RESET_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_reg,
  input  logic [4:0]  req_data,
  input  logic        req_reset_only,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] prg_ain,
  output logic [7:0]  prg_din,
  output logic        prg_write,
  output logic        busy,
  output logic        done,
  output logic [3:0]  retry_cnt,
  output logic [4:0]  shadow_ctrl,
  output logic [4:0]  shadow_chr0,
  output logic [4:0]  shadow_chr1,
  output logic [4:0]  shadow_prg
);

  mmc1_state_e state, state_nxt;
  mmc1_reg_e   lat_reg;
  logic [4:0]  lat_data;
  logic        lat_ro;
  logic        force_rst;
  logic [2:0]  idx;
  logic        started;
  logic        gap_done;

  logic        accept, lost, start, start_rst, commit;
  logic [2:0]  start_idx;

  mmc1_write_pacer #(.GAP_BEATS(GAP_BEATS)) u_pacer (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .start    (start),
    .abort    (lost || !enable),
    .write    (prg_write),
    .gap_done (gap_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (req_valid && req_ready) state_nxt = ST_ARB;
      ST_ARB:     if (ce && bus_gnt)
                    state_nxt = (RESET_FIRST != 0 || lat_ro || force_rst) ? ST_RST_WR : ST_BIT_WR;
      ST_RST_WR:  if (ce) state_nxt = bus_gnt ? ST_RST_GAP : ST_ARB;
      ST_RST_GAP: if (ce) begin
                    if (!bus_gnt)     state_nxt = ST_ARB;
                    else if (gap_done) state_nxt = lat_ro ? ST_DONE : ST_BIT_WR;
                  end
      ST_BIT_WR:  if (ce) state_nxt = bus_gnt ? ST_BIT_GAP : ST_ARB;
      ST_BIT_GAP: if (ce) begin
                    if (!bus_gnt)     state_nxt = ST_ARB;
                    else if (gap_done) state_nxt = (idx == 3'd4) ? ST_DONE : ST_BIT_WR;
                  end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
  end

  // Control strobes derive from the transition so enable-abort suppresses all of them.
  always_comb begin
    accept    = (state == ST_IDLE) && (state_nxt == ST_ARB);
    lost      = (state_nxt == ST_ARB) && (state != ST_ARB) && (state != ST_IDLE);
    start     = (state_nxt != state) && (state_nxt == ST_RST_WR || state_nxt == ST_BIT_WR);
    start_rst = (state_nxt == ST_RST_WR);
    start_idx = (state == ST_BIT_GAP) ? idx + 3'd1 : 3'd0;
    commit    = (state_nxt == ST_DONE) && (state != ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started     <= 1'b0;
      lat_reg     <= MMC1_CTRL;
      lat_data    <= 5'd0;
      lat_ro      <= 1'b0;
      force_rst   <= 1'b0;
      idx         <= 3'd0;
      retry_cnt   <= 4'd0;
      prg_ain     <= 16'h0000;
      prg_din     <= 8'h00;
      shadow_ctrl <= MMC1_CTRL_RESET;
      shadow_chr0 <= 5'd0;
      shadow_chr1 <= 5'd0;
      shadow_prg  <= 5'd0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        lat_reg   <= mmc1_reg_e'(req_reg);
        lat_data  <= req_data;
        lat_ro    <= req_reset_only;
        retry_cnt <= 4'd0;
      end
      // A lost grant leaves the MMC1 shift register in an unknown state.
      if (lost) begin
        force_rst <= 1'b1;
        if (retry_cnt != 4'hF) retry_cnt <= retry_cnt + 4'd1;
      end
      if (start) begin
        if (start_rst) begin
          prg_ain <= MMC1_BASE;
          prg_din <= MMC1_RESET_DATA;
        end else begin
          prg_ain <= mmc1_addr(lat_reg);
          prg_din <= {7'b0, lat_data[start_idx]};
          idx     <= start_idx;
        end
      end
      if (commit) begin
        force_rst <= 1'b0;
        if (lat_ro) begin
          shadow_ctrl <= shadow_ctrl | MMC1_CTRL_RESET;
        end else begin
          unique case (lat_reg)
            MMC1_CTRL: shadow_ctrl <= lat_data;
            MMC1_CHR0: shadow_chr0 <= lat_data;
            MMC1_CHR1: shadow_chr1 <= lat_data;
            MMC1_PRG:  shadow_prg  <= lat_data;
            default:   shadow_prg  <= shadow_prg;
          endcase
        end
      end
    end
  end

  assign req_ready = started && (state == ST_IDLE) && enable;
  assign busy      = (state != ST_IDLE);
  assign bus_req   = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: doc/mmc1_reg_sequencer.md
Name: mmc1_reg_sequencer

Overview:
Host-side controller that loads MMC1 internal registers by emulating the NES CPU's serial-write protocol.
- Used by the loader and savestate-restore paths; drives the mapper's prg_ain/prg_din/prg_write inputs through the CPU-bus mux, and requests that mux via a bus_req/bus_gnt handshake.
- Serialises one 5-bit register value into one optional reset write plus five single-bit writes, spaced so the MMC1 consecutive-write lockout is respected.
- Keeps a shadow copy of the values it last committed.

Parameters:
GAP_BEATS, 1, idle ce beats (prg_write low) after every write; legal range 1..7.
RESET_FIRST, 1, when 1 a $80 reset write precedes every register load.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  M2 beat strobe; all sequencing advances only on ce
enable  in  1  mapper enabled; low forces synchronous abort to IDLE
req_valid  in  1  load request
req_ready  out  1  request accepted when req_valid && req_ready on a clk edge
req_reg  in  2  target: 0 control, 1 chr_bank_0, 2 chr_bank_1, 3 prg_bank
req_data  in  5  value to load
req_reset_only  in  1  issue only the $80 reset write (req_reg/req_data ignored)
bus_req  out  1  request CPU-bus mux ownership
bus_gnt  in  1  mux granted to sequencer
prg_ain  out  16  write address
prg_din  out  8  write data
prg_write  out  1  write strobe
busy  out  1  high from accept to done
done  out  1  one-clk pulse on completion
retry_cnt  out  4  saturating count of grant-loss restarts, cleared on accept
shadow_ctrl, shadow_chr0, shadow_chr1, shadow_prg  out  5 each  last committed values

Behaviour:
- Reset values (reset_n low):
  - state IDLE; req_ready 0 until the first clk after release.
  - bus_req, prg_write, busy, done all 0; prg_ain 16'h0000, prg_din 8'h00, retry_cnt 0.
  - shadow_ctrl 5'b01100, the other shadows 0.
- States:
  - IDLE → ARB → (RST_WR → RST_GAP) → BIT_WR → BIT_GAP (×5) → DONE → IDLE.
  - req_reset_only runs ARB → RST_WR → RST_GAP → DONE.
- IDLE:
  - req_ready = enable.
  - On accept, latch reg/data/reset_only, set busy, clear retry_cnt, go to ARB.
- ARB:
  - bus_req = 1 from ARB until DONE inclusive.
  - Leave ARB on the first ce beat with bus_gnt = 1.
  - Next state is RST_WR if RESET_FIRST, reset_only, or the force-reset flag is set; otherwise BIT_WR with bit index 0.
- RST_WR:
  - prg_ain = 16'h8000, prg_din = 8'h80, prg_write = 1 for exactly one ce beat.
- BIT_WR:
  - prg_ain = {1'b1, reg, 13'h0}, giving $8000/$A000/$C000/$E000.
  - prg_din = {7'b0, data[idx]}, LSB first, prg_write = 1 for exactly one ce beat.
- *_GAP:
  - prg_write = 0 for GAP_BEATS ce beats.
  - Then advance: idx+1, or DONE after idx = 4 (or after the reset write alone for reset_only).
  - prg_ain/prg_din hold their last values during gaps; prg_write is never high on two consecutive ce beats.
- DONE (one clk):
  - done = 1, busy drops next clk, bus_req drops next clk.
  - Shadow update: the target shadow takes data; reset_only does shadow_ctrl |= 5'b01100.
- Write count per load: (RESET_FIRST ? 6 : 5) writes.
- Latency: accept to done = 1 clk + grant wait + writes·(1+GAP_BEATS) ce beats + 1 clk.
  - Example: RESET_FIRST=1, GAP_BEATS=1, immediate grant → 12 ce beats.
- Grant loss (bus_gnt = 0 on a ce beat in RST_WR/RST_GAP/BIT_WR/BIT_GAP):
  - Drop prg_write immediately, return to ARB, retry_cnt +1 (saturate at 15).
  - Set the force-reset flag: the restart always begins with the reset write, regardless of RESET_FIRST, because the MMC1 shift state is unknown.
  - The flag clears at DONE.
- enable low in any state:
  - Next clk goes to IDLE; bus_req/prg_write/busy go to 0; done is not pulsed; shadows are unchanged.
  - An in-flight request is dropped.
- Simultaneous events:
  - req_valid in the DONE clk is not accepted (req_ready = 0 outside IDLE).
  - A ce beat coinciding with grant loss counts as lost; no write is issued.
- prg_write, prg_ain, prg_din and bus_req are registered outputs (no combinational path from inputs).

Decomposition:
- Shared package mmc1_pkg holds:
  - register-select enum (MMC1_CTRL=0, MMC1_CHR0, MMC1_CHR1, MMC1_PRG);
  - constants MMC1_RESET_DATA = 8'h80, MMC1_BASE = 16'h8000, MMC1_CTRL_RESET = 5'b01100;
  - the state enum.
- One sub-module, mmc1_write_pacer: takes a one-write request plus GAP_BEATS, and produces the single-beat prg_write and a gap-complete pulse.
- The FSM, shadows and retry counter stay in the top module.

Test Plan:
- RESET_FIRST=1, GAP=1, gnt tied 1; load reg 3 with 5'b10110:
  - writes: $E000 is preceded by ($8000,$80), then $E000 with data 0,1,1,0,1;
  - done after 12 ce beats; shadow_prg = 5'b10110.
- RESET_FIRST=0, GAP=2, load reg 1 with 5'b00011:
  - exactly 5 writes to $A000, each followed by 2 idle ce beats; done after 15 ce beats.
- Grant dropped during the 3rd bit write:
  - prg_write drops that beat; retry_cnt = 1;
  - on regrant, the sequence restarts with ($8000,$80) even with RESET_FIRST=0;
  - shadow is updated only at final done.
- req_reset_only with shadow_ctrl = 5'b00010 → one write ($8000,$80); shadow_ctrl = 5'b01110.
- enable deasserted mid-load: outputs idle next clk, no done pulse, shadows unchanged; a new request is accepted once enable is high again.
- reset_n asserted mid-write with ce held:
  - prg_write falls asynchronously; all outputs take their reset values;
  - the checker confirms prg_write is never high on consecutive ce beats throughout.
